// File: rtl/while_out_fifo.sv
// rtl/while_out_fifo.sv - result FIFO with valid/ready release and saturating checksum
// Optional first-word fall-through bypass: WHILE_OUT_FIFO_BYPASS_EN.
module while_out_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ACC_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [WIDTH-1:0]           XIN,
    input  logic                       XIN_VALID,
    output logic                       XIN_READY,
    output logic [WIDTH-1:0]           XOUT,
    output logic                       XOUT_VALID,
    input  logic                       XOUT_READY,
    output logic [$clog2(DEPTH):0]     COUNT,
    input  logic                       ACC_CLR,
    output logic [ACC_WIDTH-1:0]       ACC,
    output logic                       OVF
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_base;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 empty, full, push, wr_en, fifo_pop, out_pop;
    logic [WIDTH-1:0]     head;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign head      = mem_q[rd_ptr_q];
    assign XIN_READY = !full;
    assign push      = XIN_VALID & XIN_READY;

`ifdef WHILE_OUT_FIFO_BYPASS_EN
    // When empty, an incoming item is offered straight to the consumer and
    // only lands in storage if the consumer declines it this cycle.
    assign XOUT_VALID = !empty | XIN_VALID;
    assign XOUT       = !empty ? head : (XIN_VALID ? XIN : '0);
    assign out_pop    = XOUT_VALID & XOUT_READY;
    assign wr_en      = push & !(empty & XOUT_READY);
    assign fifo_pop   = out_pop & !empty;
`else
    assign XOUT_VALID = !empty;
    assign XOUT       = empty ? '0 : head;
    assign out_pop    = XOUT_VALID & XOUT_READY;
    assign wr_en      = push;
    assign fifo_pop   = out_pop;
`endif

    // Clear is applied before the add, so clear+pop leaves just the popped value.
    assign acc_base = ACC_CLR ? '0 : acc_q;
    assign sum      = {1'b0, acc_base} + (ACC_WIDTH + 1)'(XOUT);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(fifo_pop);
        count_d  = count_q + CW'(wr_en) - CW'(fifo_pop);
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        if (ACC_CLR) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
        if (out_pop) begin
            if (sum[ACC_WIDTH]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= XIN;
        end
    end

    assign COUNT = count_q;
    assign ACC   = acc_q;
    assign OVF   = ovf_q;
endmodule

// File: tb/tb_while_out_fifo.sv
// tb/tb_while_out_fifo.sv - queue/sum reference model bench for while_out_fifo (16- and 9-bit ACC)
module tb_while_out_fifo;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] XIN = 8'h00;
    logic       XIN_VALID = 1'b0;
    logic       XOUT_READY = 1'b0;
    logic       ACC_CLR = 1'b0;

    logic        rdy_a, vld_a, ovf_a, rdy_b, vld_b, ovf_b;
    logic [7:0]  xout_a, xout_b;
    logic [2:0]  cnt_a, cnt_b;
    logic [15:0] acc_a;
    logic [8:0]  acc_b;

    int vectors = 0;
    int errors  = 0;

    always #5 CLK = ~CLK;

    while_out_fifo dut_a (
        .CLK(CLK), .RST_N(RST_N), .XIN(XIN), .XIN_VALID(XIN_VALID), .XIN_READY(rdy_a),
        .XOUT(xout_a), .XOUT_VALID(vld_a), .XOUT_READY(XOUT_READY), .COUNT(cnt_a),
        .ACC_CLR(ACC_CLR), .ACC(acc_a), .OVF(ovf_a)
    );

    while_out_fifo #(.ACC_WIDTH(9)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .XIN(XIN), .XIN_VALID(XIN_VALID), .XIN_READY(rdy_b),
        .XOUT(xout_b), .XOUT_VALID(vld_b), .XOUT_READY(XOUT_READY), .COUNT(cnt_b),
        .ACC_CLR(ACC_CLR), .ACC(acc_b), .OVF(ovf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of bytes plus one integer sum per accumulator width.
    byte unsigned q[$];
    longint       m_acc16 = 0, m_acc9 = 0;
    bit           m_ovf16 = 0, m_ovf9 = 0;
    bit           model_ok = 0;

    always @(negedge CLK) begin : compare
        int          n;
        bit          e_valid, e_ready, pop, push, bypass;
        byte unsigned e_data;
        n      = q.size();
        bypass = 0;
`ifdef WHILE_OUT_FIFO_BYPASS_EN
        bypass = (n == 0) && XIN_VALID;
`endif
        e_valid = (n != 0) || bypass;
        e_data  = (n != 0) ? q[0] : (bypass ? XIN : 8'h00);
        e_ready = (n != DEPTH);
        if (model_ok) begin
            chk("count_a", cnt_a, n);       chk("count_b", cnt_b, n);
            chk("xin_ready_a", rdy_a, e_ready); chk("xin_ready_b", rdy_b, e_ready);
            chk("xout_valid_a", vld_a, e_valid); chk("xout_valid_b", vld_b, e_valid);
            chk("xout_a", xout_a, e_data);  chk("xout_b", xout_b, e_data);
            chk("acc_a", acc_a, m_acc16[15:0]); chk("acc_b", acc_b, m_acc9[8:0]);
            chk("ovf_a", ovf_a, m_ovf16);   chk("ovf_b", ovf_b, m_ovf9);
        end
        // Advance the model to the state after the coming rising edge.
        if (!RST_N) begin
            q.delete();
            m_acc16 = 0; m_acc9 = 0; m_ovf16 = 0; m_ovf9 = 0;
            model_ok = 1;
        end else if (model_ok) begin
            push = XIN_VALID && e_ready;
            pop  = e_valid && XOUT_READY;
            if (ACC_CLR) begin
                m_acc16 = 0; m_acc9 = 0; m_ovf16 = 0; m_ovf9 = 0;
            end
            if (pop) begin
                m_acc16 += e_data;
                m_acc9  += e_data;
                if (m_acc16 > 65535) begin m_acc16 = 65535; m_ovf16 = 1; end
                if (m_acc9 > 511)    begin m_acc9 = 511;    m_ovf9 = 1;  end
                if (n != 0) void'(q.pop_front());
            end
            if (push && !(bypass && XOUT_READY)) q.push_back(XIN);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_held(input byte unsigned v);
        XIN = v; XIN_VALID = 1'b1;
        tick();
        XIN_VALID = 1'b0;
    endtask

    initial begin
        // Reset then idle
        RST_N = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
        chk("rst_count", cnt_a, 0); chk("rst_ready", rdy_a, 1);
        chk("rst_valid", vld_a, 0); chk("rst_xout", xout_a, 0);
        chk("rst_acc", acc_a, 0);   chk("rst_ovf", ovf_a, 0);

        // Fill to full, then drain with a fifth item waiting
        XOUT_READY = 1'b0;
        push_held(8'h05); push_held(8'h0A); push_held(8'h0F); push_held(8'h14);
        chk("full_count", cnt_a, 4); chk("full_ready", rdy_a, 0);
        chk("full_head", xout_a, 8'h05);
        XIN = 8'h19; XIN_VALID = 1'b1; XOUT_READY = 1'b1;
        tick();
        chk("drain_head1", xout_a, 8'h0A);
        tick();
        XIN_VALID = 1'b0;
        tick(); tick(); tick();
        chk("drain_count", cnt_a, 0); chk("drain_acc", acc_a, 16'h004B);

        // Simultaneous push/pop at COUNT=2 across pointer wrap
        XOUT_READY = 1'b0;
        push_held(8'h64); push_held(8'h65);
        XOUT_READY = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            XIN = 8'(i); XIN_VALID = 1'b1;
            tick();
            chk("wrap_count", cnt_a, 2);
        end
        chk("wrap_head", xout_a, 8'h09);
        XIN_VALID = 1'b0;
        tick(); tick();

        // Saturation on the 9-bit accumulator
        ACC_CLR = 1'b1; XOUT_READY = 1'b0;
        tick();
        ACC_CLR = 1'b0;
        push_held(8'hFF); push_held(8'hFF); push_held(8'h03);
        XOUT_READY = 1'b1;
        tick();
        chk("sat_acc1", acc_b, 9'h0FF);
        tick();
        chk("sat_acc2", acc_b, 9'h1FE); chk("sat_ovf2", ovf_b, 0);
        tick();
        chk("sat_acc3", acc_b, 9'h1FF); chk("sat_ovf3", ovf_b, 1);
        XOUT_READY = 1'b0;
        push_held(8'h07);
        ACC_CLR = 1'b1; XOUT_READY = 1'b1;
        tick();
        ACC_CLR = 1'b0;
        chk("clrpop_acc", acc_b, 9'h007); chk("clrpop_ovf", ovf_b, 0);

        // Reset mid-stream
        XOUT_READY = 1'b0;
        push_held(8'h11); push_held(8'h22); push_held(8'h33);
        chk("mid_count", cnt_a, 3);
        RST_N = 1'b0; XOUT_READY = 1'b1;
        tick();
        RST_N = 1'b1;
        chk("mid_rst_count", cnt_a, 0); chk("mid_rst_acc", acc_a, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_valid", vld_a, 0);
        end

        // Empty-queue push with consumer ready
        XIN = 8'h2A; XIN_VALID = 1'b1; XOUT_READY = 1'b1;
        #1;
`ifdef WHILE_OUT_FIFO_BYPASS_EN
        chk("byp_valid", vld_a, 1); chk("byp_xout", xout_a, 8'h2A);
        tick();
        XIN_VALID = 1'b0;
        chk("byp_count", cnt_a, 0); chk("byp_acc", acc_a, 16'h002A);
`else
        chk("nobyp_valid", vld_a, 0);
        tick();
        XIN_VALID = 1'b0;
        chk("nobyp_valid1", vld_a, 1); chk("nobyp_xout1", xout_a, 8'h2A);
        tick();
        chk("nobyp_acc", acc_a, 16'h002A);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            XIN        = 8'($urandom);
            XIN_VALID  = ($urandom_range(0, 9) < 7);
            XOUT_READY = ($urandom_range(0, 9) < 5);
            ACC_CLR    = ($urandom_range(0, 99) < 2);
            RST_N      = ($urandom_range(0, 199) != 0);
            tick();
        end
        RST_N = 1'b1; XIN_VALID = 1'b0; ACC_CLR = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/while_out_fifo.md
Name: while_out_fifo

Overview:
- Downstream buffering stage for the combinational WhileEnt datapath: captures each XOUT result (8-bit unsigned) presented with a valid flag.
- Queues results in a DEPTH-entry FIFO and releases them to the consumer over a valid/ready handshake.
- Keeps a saturating running sum of every result delivered downstream, with a sticky overflow flag; gives the consumer back-pressure and a checksum.

Parameters:
- WIDTH, 8, data width of XIN/XOUT (matches WhileEnt XOUT).
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- ACC_WIDTH, 16, accumulator width; must be > WIDTH.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset, sampled on rising CLK.
- XIN  in  WIDTH  result from upstream WhileEnt XOUT.
- XIN_VALID  in  1  XIN holds a result to push.
- XIN_READY  out  1  FIFO can accept (not full).
- XOUT  out  WIDTH  head-of-queue data.
- XOUT_VALID  out  1  XOUT valid (not empty).
- XOUT_READY  in  1  consumer accepts XOUT.
- COUNT  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- ACC_CLR  in  1  synchronous clear of ACC and OVF.
- ACC  out  ACC_WIDTH  saturating sum of popped values.
- OVF  out  1  sticky: ACC saturated at least once since last clear/reset.

Behaviour:
- Reset (RST_N=0 at edge):
  - write/read pointers=0, COUNT=0, ACC=0, OVF=0.
  - XIN_READY=1 and XOUT_VALID=0 from the first cycle after reset.
  - Storage contents are not reset.
  - Reset mid-operation discards all queued entries; no pop is counted in that cycle.
- Push = XIN_VALID & XIN_READY. Pop = XOUT_VALID & XOUT_READY.
- XIN_READY = (COUNT != DEPTH). XOUT_VALID = (COUNT != 0). Both derive from registered state only; no combinational path from XIN_VALID/XOUT_READY.
- XOUT = storage[rd_ptr] when XOUT_VALID, else 0. Masked to 0 when empty, never X.
- Latency: a push at edge N makes the entry visible (XOUT_VALID=1 if it was empty) in the cycle after edge N, i.e. 1 cycle.
- Occupancy states, derived from COUNT:
  - EMPTY(0): push only → PARTIAL (or FULL if DEPTH==1, disallowed).
  - PARTIAL: push&!pop → +1 (FULL at DEPTH); pop&!push → -1 (EMPTY at 0); push&pop → unchanged.
  - FULL(DEPTH): XIN_READY=0, so push is impossible; pop → PARTIAL.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; data order is strictly FIFO across wrap.
- Accumulator update on each edge:
  - sum = ACC_WIDTH+1-bit (ACC + zero-extended XOUT).
  - Pop without ACC_CLR: if sum > 2^ACC_WIDTH-1, ACC=all-ones and OVF=1; else ACC=sum.
  - ACC_CLR without pop: ACC=0, OVF=0.
  - ACC_CLR with pop: clear first, then add, so ACC=XOUT and OVF=0.
  - Neither: hold.
- XIN is ignored when XIN_VALID=0. XOUT_READY is ignored when empty.

Optional Feature:
- Macro WHILE_OUT_FIFO_BYPASS_EN.
- Defined: first-word fall-through bypass. When COUNT==0 and XIN_VALID=1:
  - XOUT=XIN and XOUT_VALID=1 combinationally.
  - If XOUT_READY=1 in that cycle, the item is consumed directly (counted in ACC) and not written; COUNT stays 0.
  - If XOUT_READY=0, it is written normally.
  - Zero-cycle latency when empty; introduces a comb path XIN_VALID→XOUT_VALID.
- Undefined: no bypass; minimum latency 1 cycle, all outputs registered-derived as above.

Test Plan:
- Reset then idle: RST_N low 2 cycles → COUNT=0, XIN_READY=1, XOUT_VALID=0, XOUT=0, ACC=0, OVF=0.
- Fill/drain: push 0x05,0x0A,0x0F,0x14 with XOUT_READY=0 → COUNT=4, XIN_READY=0. A fifth push 0x19 held. Then XOUT_READY=1 → pops 0x05,0x0A,0x0F,0x14 in order, then 0x19. ACC=0x4B.
- Wrap/simultaneous: hold COUNT=2, push and pop every cycle for 10 cycles with values 1..10 → COUNT stays 2, output order preserved across pointer wrap.
- Saturation: ACC_WIDTH=9, pop 0xFF,0xFF,0x03 → ACC=0x1FE, then 0x1FF, OVF=1. ACC_CLR with simultaneous pop of 0x07 → ACC=0x007, OVF=0.
- Reset mid-stream: COUNT=3, RST_N=0 for one edge with XOUT_READY=1 → COUNT=0, ACC=0, no further data emitted.
- Bypass (macro defined): empty, XIN=0x2A valid, XOUT_READY=1 → same cycle XOUT=0x2A, XOUT_VALID=1. Next cycle COUNT=0, ACC=0x2A. Macro undefined: XOUT_VALID first high the next cycle.
